y_ctrl_fsm: RTL and testbench
=============================

// Module: y_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB RISC-V datapath.
//  Decodes ins from yIF and sequences RegWrite, ALUSrc, op, MemRead, MemWrite,
//  Mem2Reg plus IR/PC update strobes through FETCH/DECODE/EXEC/MEM/WB.
//  Consumes zero from yEX for branch resolution.
//  Counts retired instructions and halts on unsupported encodings.
// PARAMETERS
//  CNT_W            16  width of instr_count
//  HALT_ON_ILLEGAL  1   1: illegal -> HALT; 0: illegal retired as NOP
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  ins          in   32     current instruction from yIF
//  zero         in   1      ALU zero flag from yEX
//  IRWrite      out  1      latch instruction / IF stage enable
//  RegWrite     out  1      register-file write enable (yID)
//  ALUSrc       out  1      0: rd2, 1: imm
//  op           out  3      ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//  MemRead      out  1      yDM read enable
//  MemWrite     out  1      yDM write enable
//  Mem2Reg      out  1      yWB select: 0 z, 1 memOut
//  PCWrite      out  1      PC register load strobe
//  PCSel        out  2      PC source: 00 PCp4, 01 branch, 10 jTarget
//  state        out  3      IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6
//  illegal      out  1      sticky; unsupported encoding decoded
//  instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - All outputs are registered and reflect the current state.
//  - Reset, taken at any state including mid-instruction:
//    state=IDLE, all strobes 0, op=010, PCSel=00, illegal=0, instr_count=0.
//  - IDLE -> FETCH unconditionally.
//  - FETCH: IRWrite=1 for one cycle -> DECODE.
//  - DECODE: latch opcode ins[6:0], funct3 ins[14:12], funct7 ins[31:25].
//    Unsupported encoding: illegal<=1, then -> HALT if HALT_ON_ILLEGAL,
//    else -> WB as NOP. Supported encoding -> EXEC.
//  - Supported encodings:
//    0x33: add f3=0/f7=00 -> 010, sub f3=0/f7=20 -> 110, slt 2 -> 111,
//      or 6 -> 001, and 7 -> 000.
//    0x13: addi 0, slti 2, ori 6, andi 7.
//    0x03: lw f3=2.  0x23: sw f3=2.  0x63: beq f3=0, bne f3=1.  0x6F: jal.
//  - ALUSrc/op hold the decoded value from EXEC entry through WB exit;
//    elsewhere ALUSrc=0, op=010.
//    ALUSrc=1 for I/load/store, 0 for R/branch. Branch op=110.
//    Load/store op=010.
//  - EXEC: R/I/branch/jal -> WB; load/store -> MEM.
//    Branch samples zero on the last EXEC edge:
//    taken = zero (beq) or !zero (bne).
//  - MEM: MemRead=1 (load) or MemWrite=1 (store) for one cycle -> WB.
//  - WB: PCWrite=1 for one cycle. RegWrite=1 for R/I/load.
//    Mem2Reg=1 for load. PCSel=01 if branch taken, 10 for jal, else 00.
//    jal does not write a link register. WB -> FETCH.
//  - Latency: R/I/branch/jal 4 cycles FETCH..WB; load/store 5.
//  - MemRead and MemWrite are never both 1. RegWrite and MemWrite are never
//    both 1.
//  - instr_count increments on leaving WB, including illegal-as-NOP, and
//    wraps modulo 2^CNT_W.
//  - HALT: all strobes 0, illegal=1; exits only on reset.
// TESTING
//  - Reset 3 cycles, then addi x1,x0,5 (0x00500093):
//    FETCH, DECODE, EXEC (ALUSrc=1, op=010), WB (RegWrite=1, PCWrite=1, PCSel=00);
//    instr_count=1.
//  - sub (0x40208133): EXEC op=110 ALUSrc=0; WB RegWrite=1, Mem2Reg=0.
//  - lw (0x0000A183): MEM MemRead=1, then WB RegWrite=1, Mem2Reg=1.
//    sw (0x0030A223): MEM MemWrite=1; WB RegWrite=0. Both take 5 cycles.
//  - beq (0x00208463), zero=1 in EXEC -> WB PCSel=01;
//    zero=0 -> PCSel=00. bne with zero=0 -> PCSel=01.
//    jal (0x0080006F) -> PCSel=10, RegWrite=0.
//  - Illegal opcode 0x7F with HALT_ON_ILLEGAL=1 -> HALT, illegal=1,
//    no strobes for 10 cycles.
//    Reset asserted in MEM of lw -> next cycle IDLE, MemRead=0, instr_count=0.
//  - CNT_W=2: run 5 addi -> instr_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/y_ctrl_fsm.sv
// y_ctrl_fsm: multi-cycle control unit for the yIF/yID/yEX/yDM/yWB datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, decodes the RV32 subset the datapath
// supports, resolves branches from the ALU zero flag, counts retired
// instructions and halts (or NOPs) on unsupported encodings.
// Every output is a flop whose next value is computed from the next state.
module y_ctrl_fsm #(
  parameter int unsigned CNT_W           = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    K_NOP = 3'd0, K_R = 3'd1, K_I = 3'd2, K_LD = 3'd3,
    K_ST = 3'd4, K_BR = 3'd5, K_JAL = 3'd6
  } kind_e;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_ins_s;

  assign opcode_s     = ins[6:0];
  assign funct3_s     = ins[14:12];
  assign funct7_s     = ins[31:25];
  // Register and immediate fields are the datapath's business, not ours.
  assign unused_ins_s = ^{ins[24:15], ins[11:7]};

  logic       dec_legal_s;
  kind_e      dec_kind_s;
  logic [2:0] dec_op_s;
  logic       dec_src_s;
  logic       dec_bne_s;

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d;
  logic [2:0] aop_q, aop_d;
  logic       asrc_q, asrc_d;
  logic       bne_q, bne_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       irwrite_q, irwrite_d;
  logic       regwrite_q, regwrite_d;
  logic       alusrc_q, alusrc_d;
  logic [2:0] op_q, op_d;
  logic       memread_q, memread_d;
  logic       memwrite_q, memwrite_d;
  logic       mem2reg_q, mem2reg_d;
  logic       pcwrite_q, pcwrite_d;
  logic [1:0] pcsel_q, pcsel_d;

  // Decode the instruction word into class, ALU op, operand select and legality.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_kind_s  = K_NOP;
    dec_op_s    = OP_ADD;
    dec_src_s   = 1'b0;
    dec_bne_s   = 1'b0;
    case (opcode_s)
      7'h33: begin
        dec_kind_s = K_R;
        case (funct3_s)
          3'd0: begin
            if (funct7_s == 7'h00) begin
              dec_legal_s = 1'b1;
              dec_op_s    = OP_ADD;
            end else if (funct7_s == 7'h20) begin
              dec_legal_s = 1'b1;
              dec_op_s    = OP_SUB;
            end else begin
              dec_legal_s = 1'b0;
            end
          end
          3'd2: begin dec_legal_s = (funct7_s == 7'h00); dec_op_s = OP_SLT; end
          3'd6: begin dec_legal_s = (funct7_s == 7'h00); dec_op_s = OP_OR;  end
          3'd7: begin dec_legal_s = (funct7_s == 7'h00); dec_op_s = OP_AND; end
          default: dec_legal_s = 1'b0;
        endcase
      end
      7'h13: begin
        dec_kind_s = K_I;
        dec_src_s  = 1'b1;
        case (funct3_s)
          3'd0: begin dec_legal_s = 1'b1; dec_op_s = OP_ADD; end
          3'd2: begin dec_legal_s = 1'b1; dec_op_s = OP_SLT; end
          3'd6: begin dec_legal_s = 1'b1; dec_op_s = OP_OR;  end
          3'd7: begin dec_legal_s = 1'b1; dec_op_s = OP_AND; end
          default: dec_legal_s = 1'b0;
        endcase
      end
      7'h03: begin
        dec_kind_s  = K_LD;
        dec_src_s   = 1'b1;
        dec_legal_s = (funct3_s == 3'd2);
      end
      7'h23: begin
        dec_kind_s  = K_ST;
        dec_src_s   = 1'b1;
        dec_legal_s = (funct3_s == 3'd2);
      end
      7'h63: begin
        dec_kind_s = K_BR;
        dec_op_s   = OP_SUB;
        case (funct3_s)
          3'd0:    dec_legal_s = 1'b1;
          3'd1:    begin dec_legal_s = 1'b1; dec_bne_s = 1'b1; end
          default: dec_legal_s = 1'b0;
        endcase
      end
      // jal uses no ALU operand from the register file; keep rd2 / add.
      7'h6F: begin
        dec_kind_s  = K_JAL;
        dec_legal_s = 1'b1;
      end
      default: dec_legal_s = 1'b0;
    endcase
  end

  // Next-state sequencing plus the registered output values for that next state.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    aop_d     = aop_q;
    asrc_d    = asrc_q;
    bne_d     = bne_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        taken_d = 1'b0;
        if (dec_legal_s) begin
          kind_d  = dec_kind_s;
          aop_d   = dec_op_s;
          asrc_d  = dec_src_s;
          bne_d   = dec_bne_s;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          kind_d    = K_NOP;
          aop_d     = OP_ADD;
          asrc_d    = 1'b0;
          bne_d     = 1'b0;
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_EXEC: begin
        // Branch outcome is frozen from zero on the edge that leaves EXEC.
        if (kind_q == K_BR) begin
          taken_d = bne_q ? !zero : zero;
        end else begin
          taken_d = 1'b0;
        end
        if ((kind_q == K_LD) || (kind_q == K_ST)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    irwrite_d  = 1'b0;
    regwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    op_d       = OP_ADD;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    mem2reg_d  = 1'b0;
    pcwrite_d  = 1'b0;
    pcsel_d    = 2'b00;
    case (state_d)
      S_FETCH: irwrite_d = 1'b1;
      S_EXEC: begin
        alusrc_d = asrc_d;
        op_d     = aop_d;
      end
      S_MEM: begin
        alusrc_d   = asrc_d;
        op_d       = aop_d;
        memread_d  = (kind_d == K_LD);
        memwrite_d = (kind_d == K_ST);
      end
      S_WB: begin
        alusrc_d   = asrc_d;
        op_d       = aop_d;
        pcwrite_d  = 1'b1;
        regwrite_d = (kind_d == K_R) || (kind_d == K_I) || (kind_d == K_LD);
        mem2reg_d  = (kind_d == K_LD);
        if (kind_d == K_JAL) begin
          pcsel_d = 2'b10;
        end else if ((kind_d == K_BR) && taken_d) begin
          pcsel_d = 2'b01;
        end else begin
          pcsel_d = 2'b00;
        end
      end
      default: pcsel_d = 2'b00;
    endcase
  end

  // State, decoded-instruction and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_NOP;
      aop_q      <= OP_ADD;
      asrc_q     <= 1'b0;
      bne_q      <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      irwrite_q  <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      op_q       <= OP_ADD;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      mem2reg_q  <= 1'b0;
      pcwrite_q  <= 1'b0;
      pcsel_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      aop_q      <= aop_d;
      asrc_q     <= asrc_d;
      bne_q      <= bne_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
      irwrite_q  <= irwrite_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      op_q       <= op_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      mem2reg_q  <= mem2reg_d;
      pcwrite_q  <= pcwrite_d;
      pcsel_q    <= pcsel_d;
    end
  end

  assign IRWrite     = irwrite_q;
  assign RegWrite    = regwrite_q;
  assign ALUSrc      = alusrc_q;
  assign op          = op_q;
  assign MemRead     = memread_q;
  assign MemWrite    = memwrite_q;
  assign Mem2Reg     = mem2reg_q;
  assign PCWrite     = pcwrite_q;
  assign PCSel       = pcsel_q;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_y_ctrl_fsm.sv
// Self-checking bench for y_ctrl_fsm: two instances share stimulus, one with
// default parameters (halt on illegal) and one with CNT_W=2 and illegal-as-NOP.
// Expected per-cycle outputs come from a table of supported encodings.
module tb_y_ctrl_fsm;

  localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4, KJ = 5;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         use_f3;
    bit         use_f7;
    int         kind;
    logic [2:0] aop;
    bit         asrc;
    bit         is_bne;
  } enc_t;

  enc_t tbl[$];

  logic clk = 1'b0;
  logic reset;
  logic zero;
  logic [31:0] ins;

  logic irw1, rw1, as1, mr1, mw1, m2r1, pcw1, ill1;
  logic [2:0] op1, st1;
  logic [1:0] pcs1;
  logic [15:0] cnt1;
  logic irw2, rw2, as2, mr2, mw2, m2r2, pcw2, ill2;
  logic [2:0] op2, st2;
  logic [1:0] pcs2;
  logic [1:0] cnt2;
  logic [14:0] obs1, obs2;

  int total = 0;
  int bad = 0;
  int count_m = 0;

  assign obs1 = {irw1, rw1, as1, op1, mr1, mw1, m2r1, pcw1, pcs1, st1};
  assign obs2 = {irw2, rw2, as2, op2, mr2, mw2, m2r2, pcw2, pcs2, st2};

  y_ctrl_fsm dut1 (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero),
    .IRWrite(irw1), .RegWrite(rw1), .ALUSrc(as1), .op(op1),
    .MemRead(mr1), .MemWrite(mw1), .Mem2Reg(m2r1), .PCWrite(pcw1),
    .PCSel(pcs1), .state(st1), .illegal(ill1), .instr_count(cnt1)
  );

  y_ctrl_fsm #(.CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero),
    .IRWrite(irw2), .RegWrite(rw2), .ALUSrc(as2), .op(op2),
    .MemRead(mr2), .MemWrite(mw2), .Mem2Reg(m2r2), .PCWrite(pcw2),
    .PCSel(pcs2), .state(st2), .illegal(ill2), .instr_count(cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ev(input logic irw, input logic rw, input logic as_v,
                                     input logic [2:0] aop, input logic mr, input logic mw,
                                     input logic m2r, input logic pcw, input logic [1:0] pcs,
                                     input logic [2:0] st);
    return {irw, rw, as_v, aop, mr, mw, m2r, pcw, pcs, st};
  endfunction

  function automatic int lookup(input logic [31:0] iv);
    for (int i = 0; i < tbl.size(); i++) begin
      if (iv[6:0] == tbl[i].opc &&
          (!tbl[i].use_f3 || iv[14:12] == tbl[i].f3) &&
          (!tbl[i].use_f7 || iv[31:25] == tbl[i].f7))
        return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    count_m = 0;
  endtask

  // Runs one supported instruction from FETCH through WB on both instances.
  task automatic run_instr(input logic [31:0] iv, input bit z, input string nm);
    int k;
    enc_t e;
    bit ld, st, taken;
    logic [1:0] pcs;
    logic [14:0] exp_q[$];
    k = lookup(iv);
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL %s model: encoding %h not in table, required a supported one", nm, iv);
      return;
    end
    e = tbl[k];
    ld = (e.kind == KLD);
    st = (e.kind == KST);
    taken = (e.kind == KBR) && (e.is_bne ? !z : z);
    pcs = (e.kind == KJ) ? 2'b10 : (taken ? 2'b01 : 2'b00);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1));
    exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd2));
    exp_q.push_back(ev(1'b0, 1'b0, e.asrc, e.aop, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd3));
    if (ld || st)
      exp_q.push_back(ev(1'b0, 1'b0, e.asrc, e.aop, ld, st, 1'b0, 1'b0, 2'b00, 3'd4));
    exp_q.push_back(ev(1'b0, (e.kind == KR || e.kind == KI || ld), e.asrc, e.aop,
                       1'b0, 1'b0, ld, 1'b1, pcs, 3'd5));
    ins = iv;
    for (int c = 0; c < exp_q.size(); c++) begin
      zero = (c == 2) ? z : 1'($urandom_range(0, 1));
      total++;
      if (obs1 !== exp_q[c]) begin
        bad++;
        $display("FAIL %s dut1 cyc%0d outputs got=%h want=%h", nm, c, obs1, exp_q[c]);
      end
      total++;
      if (obs2 !== exp_q[c]) begin
        bad++;
        $display("FAIL %s dut2 cyc%0d outputs got=%h want=%h", nm, c, obs2, exp_q[c]);
      end
      total++;
      if (cnt1 !== 16'(count_m) || cnt2 !== 2'(count_m) || ill1 !== 1'b0 || ill2 !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc%0d count/illegal got=%0d,%0d,%b,%b want=%0d,%0d,0,0",
                 nm, c, cnt1, cnt2, ill1, ill2, 16'(count_m), 2'(count_m));
      end
      step();
    end
    count_m++;
  endtask

  task automatic test_reset();
    ins = 32'h0000_0000;
    zero = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    total++;
    if (obs1 !== ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0) ||
        obs2 !== ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0) ||
        cnt1 !== 16'd0 || cnt2 !== 2'd0 || ill1 !== 1'b0 || ill2 !== 1'b0) begin
      bad++;
      $display("FAIL reset got=%h/%h cnt=%0d/%0d ill=%b/%b want IDLE op=010 zeros",
               obs1, obs2, cnt1, cnt2, ill1, ill2);
    end
    reset = 1'b0;
    step();
    count_m = 0;
  endtask

  task automatic test_directed();
    run_instr(32'h0050_0093, 1'b0, "addi");
    run_instr(32'h4020_8133, 1'b0, "sub");
    run_instr(32'h0000_A183, 1'b0, "lw");
    run_instr(32'h0030_A223, 1'b1, "sw");
    run_instr(32'h0020_8463, 1'b1, "beq_taken");
    run_instr(32'h0020_8463, 1'b0, "beq_not");
    run_instr(32'h0020_9463, 1'b0, "bne_taken");
    run_instr(32'h0020_9463, 1'b1, "bne_not");
    run_instr(32'h0080_006F, 1'b0, "jal");
  endtask

  task automatic test_random();
    enc_t e;
    logic [31:0] iv;
    for (int n = 0; n < 40; n++) begin
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      iv = $urandom;
      iv[6:0] = e.opc;
      if (e.use_f3) iv[14:12] = e.f3;
      if (e.use_f7) iv[31:25] = e.f7;
      run_instr(iv, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid();
    ins = 32'h0000_A183;
    step();
    step();
    step();
    total++;
    if (mr1 !== 1'b1 || st1 !== 3'd4) begin
      bad++;
      $display("FAIL reset_mid pre MemRead/state got=%b/%0d want=1/4", mr1, st1);
    end
    reset = 1'b1;
    step();
    total++;
    if (st1 !== 3'd0 || mr1 !== 1'b0 || cnt1 !== 16'd0 || cnt2 !== 2'd0 || st2 !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid got state=%0d MemRead=%b cnt=%0d/%0d want 0 0 0/0",
               st1, mr1, cnt1, cnt2);
    end
    reset = 1'b0;
    step();
    count_m = 0;
  endtask

  task automatic test_illegal();
    logic [31:0] bad_enc[3];
    logic [2:0] hs;
    bad_enc[0] = 32'h0000_007F;
    bad_enc[1] = 32'h0200_0033;
    bad_enc[2] = 32'h0000_1013;
    for (int b = 0; b < 3; b++) begin
      hs = (lookup(bad_enc[b]) < 0) ? 3'd6 : 3'd3;
      ins = bad_enc[b];
      zero = 1'b0;
      step();
      step();
      total++;
      if (obs1 !== ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, hs) ||
          ill1 !== 1'b1) begin
        bad++;
        $display("FAIL illegal_halt enc=%h got=%h ill=%b want=%h ill=1", bad_enc[b], obs1, ill1,
                 ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, hs));
      end
      total++;
      if (obs2 !== ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'd5) ||
          ill2 !== 1'b1) begin
        bad++;
        $display("FAIL illegal_nop enc=%h got=%h ill=%b want WB nop ill=1", bad_enc[b], obs2, ill2);
      end
      ins = 32'h0050_0093;
      for (int i = 0; i < 10; i++) begin
        step();
        total++;
        if (obs1 !== ev(1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd6) ||
            ill1 !== 1'b1 || cnt1 !== 16'(count_m)) begin
          bad++;
          $display("FAIL halt_hold cyc%0d got=%h ill=%b cnt=%0d want HALT ill=1 cnt=%0d",
                   i, obs1, ill1, cnt1, 16'(count_m));
        end
        if (i == 0) begin
          total++;
          if (st2 !== 3'd1 || ill2 !== 1'b1 || cnt2 !== 2'(count_m + 1)) begin
            bad++;
            $display("FAIL nop_retire got state=%0d ill=%b cnt=%0d want 1 1 %0d",
                     st2, ill2, cnt2, 2'(count_m + 1));
          end
        end
      end
      do_reset();
    end
  endtask

  task automatic test_cnt_wrap();
    int seq[5];
    seq = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_instr(32'h0050_0093, 1'b0, "wrap_addi");
      total++;
      if (cnt2 !== 2'(seq[i]) || cnt1 !== 16'(i + 1)) begin
        bad++;
        $display("FAIL cnt_wrap step%0d got=%0d/%0d want=%0d/%0d", i, cnt2, cnt1, seq[i], i + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{7'h33, 3'd0, 7'h00, 1'b1, 1'b1, KR, 3'b010, 1'b0, 1'b0});
    tbl.push_back('{7'h33, 3'd0, 7'h20, 1'b1, 1'b1, KR, 3'b110, 1'b0, 1'b0});
    tbl.push_back('{7'h33, 3'd2, 7'h00, 1'b1, 1'b1, KR, 3'b111, 1'b0, 1'b0});
    tbl.push_back('{7'h33, 3'd6, 7'h00, 1'b1, 1'b1, KR, 3'b001, 1'b0, 1'b0});
    tbl.push_back('{7'h33, 3'd7, 7'h00, 1'b1, 1'b1, KR, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{7'h13, 3'd0, 7'h00, 1'b1, 1'b0, KI, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{7'h13, 3'd2, 7'h00, 1'b1, 1'b0, KI, 3'b111, 1'b1, 1'b0});
    tbl.push_back('{7'h13, 3'd6, 7'h00, 1'b1, 1'b0, KI, 3'b001, 1'b1, 1'b0});
    tbl.push_back('{7'h13, 3'd7, 7'h00, 1'b1, 1'b0, KI, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{7'h03, 3'd2, 7'h00, 1'b1, 1'b0, KLD, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{7'h23, 3'd2, 7'h00, 1'b1, 1'b0, KST, 3'b010, 1'b1, 1'b0});
    tbl.push_back('{7'h63, 3'd0, 7'h00, 1'b1, 1'b0, KBR, 3'b110, 1'b0, 1'b0});
    tbl.push_back('{7'h63, 3'd1, 7'h00, 1'b1, 1'b0, KBR, 3'b110, 1'b0, 1'b1});
    tbl.push_back('{7'h6F, 3'd0, 7'h00, 1'b0, 1'b0, KJ, 3'b010, 1'b0, 1'b0});

    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_illegal();
    test_cnt_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
